// File: rtl/ahb_aes_queue_slave.sv
// AHB-Lite zero-wait register slave that queues plaintext blocks for an
// external AES-128 core and collects the ciphertext in an output FIFO.
// A small dispatch FSM feeds the core one job at a time, snapshotting the key
// per job. Illegal accesses get a two-cycle ERROR response and no side effects.
module ahb_aes_queue_slave #(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int          ADDR_WIDTH = 32,
   parameter int          IN_DEPTH   = 4,
   parameter int          OUT_DEPTH  = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSELx,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   input  logic [31:0]           HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic                  irq,
   output logic                  aes_start,
   output logic [127:0]          aes_key,
   output logic [127:0]          aes_din,
   input  logic [127:0]          aes_dout,
   input  logic                  aes_done
);

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam int IN_CW  = $clog2(IN_DEPTH + 1);
   localparam int IN_PW  = $clog2(IN_DEPTH);
   localparam int OUT_CW = $clog2(OUT_DEPTH + 1);
   localparam int OUT_PW = $clog2(OUT_DEPTH);

   localparam logic [3:0] IDX_DIN3    = 4'd7;
   localparam logic [3:0] IDX_CTRL    = 4'd8;
   localparam logic [3:0] IDX_STATUS  = 4'd9;
   localparam logic [3:0] IDX_STATCLR = 4'd10;
   localparam logic [3:0] IDX_DOUT3   = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

   // Bus pipeline
   logic       addr_sel, in_window, acc_err;
   logic [3:0] a_idx;
   logic       dp_valid, dp_write, err_c1, err_c2;
   logic [3:0] dp_idx;

   // Register file
   logic [3:0][31:0] key_q;
   logic [2:0][31:0] din_q;
   logic             en, irq_en, ovf, udf;

   // Data-phase strobes
   logic wr_en, rd_en, ctrl_we, statclr_we, din3_we, dout3_rd, flush;
   logic ovf_set, udf_set;

   // FIFOs
   logic [127:0]      in_mem  [IN_DEPTH];
   logic [127:0]      out_mem [OUT_DEPTH];
   logic [IN_PW-1:0]  in_wr, in_rd;
   logic [OUT_PW-1:0] out_wr, out_rd;
   logic [IN_CW-1:0]  in_count;
   logic [OUT_CW-1:0] out_count;
   logic              in_full, in_empty, out_full, out_empty;
   logic              in_push, in_pop, out_push, out_pop;
   logic [127:0]      in_block, out_head;
   logic [3:0][31:0]  out_words;

   // Dispatch FSM
   state_t state, state_next;
   logic   key_load;

   logic unused_bits;
   assign unused_bits = ^{HTRANS[0], HADDR[1:0]};

   assign addr_sel  = HSELx & HREADY & HTRANS[1];
   assign in_window = (HADDR[ADDR_WIDTH-1:6] == BASE[ADDR_WIDTH-1:6]);
   assign a_idx     = HADDR[5:2];

   // Classify the address-phase access as legal or as an ERROR.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is never inferred.
   always_comb begin
      acc_err = 1'b0;
      if (!in_window || (HSIZE != 3'b010)) begin
         acc_err = 1'b1;
      end else begin
         case (a_idx)
            4'd4, 4'd5, 4'd6, 4'd7:           acc_err = !HWRITE;
            4'd9, 4'd12, 4'd13, 4'd14, 4'd15: acc_err = HWRITE;
            4'd11:                            acc_err = 1'b1;
            default:                          acc_err = 1'b0;
         endcase
      end
   end

   // Register the address phase; an illegal access enters the two-cycle ERROR sequence.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_idx   <= '0;
         err_c1   <= 1'b0;
         err_c2   <= 1'b0;
      end else begin
         dp_valid <= addr_sel & !acc_err;
         dp_write <= HWRITE;
         dp_idx   <= a_idx;
         err_c1   <= addr_sel & acc_err;
         err_c2   <= err_c1;
      end
   end

   assign HREADYOUT = !err_c1;
   assign HRESP     = err_c1 | err_c2;

   assign wr_en      = dp_valid & dp_write;
   assign rd_en      = dp_valid & !dp_write;
   assign ctrl_we    = wr_en & (dp_idx == IDX_CTRL);
   assign statclr_we = wr_en & (dp_idx == IDX_STATCLR);
   assign din3_we    = wr_en & (dp_idx == IDX_DIN3);
   assign dout3_rd   = rd_en & (dp_idx == IDX_DOUT3);
   assign flush      = ctrl_we & HWDATA[2];

   assign in_full   = (in_count == IN_CW'(IN_DEPTH));
   assign in_empty  = (in_count == '0);
   assign out_full  = (out_count == OUT_CW'(OUT_DEPTH));
   assign out_empty = (out_count == '0);

   // Full/empty are judged on pre-edge counts, so a same-cycle pop never rescues a push.
   assign in_push  = din3_we & !in_full;
   assign ovf_set  = din3_we & in_full;
   assign out_pop  = dout3_rd & !out_empty;
   assign udf_set  = dout3_rd & out_empty;
   assign in_block = {HWDATA, din_q[2], din_q[1], din_q[0]};

   // Software-visible registers: key, staged block, control and sticky flags.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         key_q  <= '0;
         din_q  <= '0;
         en     <= 1'b0;
         irq_en <= 1'b0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wr_en && (dp_idx == 4'(i))) key_q[i] <= HWDATA;
         end
         if (flush) begin
            din_q <= '0;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (wr_en && (dp_idx == 4'(i + 4))) din_q[i] <= HWDATA;
            end
         end
         if (ctrl_we) begin
            en     <= HWDATA[0];
            irq_en <= HWDATA[1];
         end
         if (ovf_set)                       ovf <= 1'b1;
         else if (statclr_we && HWDATA[5])  ovf <= 1'b0;
         if (udf_set)                       udf <= 1'b1;
         else if (statclr_we && HWDATA[6])  udf <= 1'b0;
      end
   end

   // Key snapshot for the core and the registered interrupt level.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         aes_key <= '0;
         irq     <= 1'b0;
      end else begin
         if (key_load) aes_key <= key_q;
         irq <= irq_en & !out_empty;
      end
   end

   // Input FIFO payload storage.
   // NOTE: FIFO payload has no reset; the reset pointers and count guarantee stale entries are never consumed.
   always_ff @(posedge HCLK) begin
      if (in_push) in_mem[in_wr] <= in_block;
   end

   // Input FIFO pointers and occupancy; FLUSH empties it.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         in_wr    <= '0;
         in_rd    <= '0;
         in_count <= '0;
      end else if (flush) begin
         in_wr    <= '0;
         in_rd    <= '0;
         in_count <= '0;
      end else begin
         if (in_push) in_wr <= (in_wr == IN_PW'(IN_DEPTH - 1)) ? '0 : in_wr + IN_PW'(1);
         if (in_pop)  in_rd <= (in_rd == IN_PW'(IN_DEPTH - 1)) ? '0 : in_rd + IN_PW'(1);
         case ({in_push, in_pop})
            2'b10:   in_count <= in_count + IN_CW'(1);
            2'b01:   in_count <= in_count - IN_CW'(1);
            default: in_count <= in_count;
         endcase
      end
   end

   // Output FIFO payload storage.
   always_ff @(posedge HCLK) begin
      if (out_push) out_mem[out_wr] <= aes_dout;
   end

   // Output FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         out_wr    <= '0;
         out_rd    <= '0;
         out_count <= '0;
      end else if (flush) begin
         out_wr    <= '0;
         out_rd    <= '0;
         out_count <= '0;
      end else begin
         if (out_push) out_wr <= (out_wr == OUT_PW'(OUT_DEPTH - 1)) ? '0 : out_wr + OUT_PW'(1);
         if (out_pop)  out_rd <= (out_rd == OUT_PW'(OUT_DEPTH - 1)) ? '0 : out_rd + OUT_PW'(1);
         case ({out_push, out_pop})
            2'b10:   out_count <= out_count + OUT_CW'(1);
            2'b01:   out_count <= out_count - OUT_CW'(1);
            default: out_count <= out_count;
         endcase
      end
   end

   assign aes_din   = in_mem[in_rd];
   assign out_head  = out_mem[out_rd];
   assign out_words = out_head;

   // Dispatch FSM state register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= S_IDLE;
      else          state <= state_next;
   end

   // Dispatch FSM next state and strobes; output space is reserved before a job is issued.
   always_comb begin
      state_next = state;
      aes_start  = 1'b0;
      key_load   = 1'b0;
      in_pop     = 1'b0;
      out_push   = 1'b0;
      case (state)
         S_IDLE: begin
            if (en && !in_empty && !out_full && !flush) begin
               state_next = S_ISSUE;
               key_load   = 1'b1;
            end
         end
         S_ISSUE: begin
            aes_start  = 1'b1;
            state_next = flush ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (aes_done) begin
               state_next = S_IDLE;
               if (!flush) begin
                  out_push = 1'b1;
                  in_pop   = 1'b1;
               end
            end else if (flush) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (aes_done) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Zero-wait read data for the current data phase.
   always_comb begin
      HRDATA = '0;
      if (rd_en) begin
         case (dp_idx)
            4'd0, 4'd1, 4'd2, 4'd3:     HRDATA = key_q[dp_idx[1:0]];
            IDX_CTRL:                   HRDATA = {30'b0, irq_en, en};
            IDX_STATUS:                 HRDATA = {16'b0, 4'(out_count), 4'(in_count), 1'b0,
                                                  udf, ovf, out_empty, out_full,
                                                  in_empty, in_full, (state != S_IDLE)};
            4'd12, 4'd13, 4'd14, 4'd15: HRDATA = out_empty ? 32'h0 : out_words[dp_idx[1:0]];
            default:                    HRDATA = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_aes_queue_slave.sv
// Bench for ahb_aes_queue_slave: a behavioural core model, a queue-based
// reference model of the register/FIFO behaviour, randomized operations, and
// directed scenarios for the FIPS-197 vector, overflow, stall, errors, flush,
// irq and reset.
module tb_ahb_aes_queue_slave;

   localparam logic [31:0] BASE      = 32'h4000_0000;
   localparam int          IN_DEPTH  = 4;
   localparam int          OUT_DEPTH = 4;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   localparam logic [31:0] O_KEY = 32'h00, O_DIN = 32'h10, O_CTRL = 32'h20;
   localparam logic [31:0] O_STAT = 32'h24, O_CLR = 32'h28, O_DOUT = 32'h30;

   logic         HCLK = 1'b0, HRESETn = 1'b0;
   logic         HSELx = 1'b0, HWRITE = 1'b0;
   logic [31:0]  HADDR = '0, HWDATA = '0;
   logic [2:0]   HSIZE = 3'b010;
   logic [1:0]   HTRANS = 2'b00;
   logic         HREADY, HREADYOUT, HRESP, irq, aes_start;
   logic [31:0]  HRDATA;
   logic [127:0] aes_key, aes_din;
   logic [127:0] aes_dout = '0;
   logic         aes_done = 1'b0;

   assign HREADY = HREADYOUT;

   ahb_aes_queue_slave #(
      .BASE_ADDR(BASE), .ADDR_WIDTH(32), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .irq(irq),
      .aes_start(aes_start), .aes_key(aes_key), .aes_din(aes_din),
      .aes_dout(aes_dout), .aes_done(aes_done)
   );

   always #5 HCLK = ~HCLK;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Stand-in AES core: the FIPS-197 vector is honoured, anything else gets a keyed mix.
   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
      if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
      return {d[95:0], d[127:96]} ^ k ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
   endfunction

   int           core_lat = 4;
   int           core_cnt = 0;
   int           starts = 0;
   logic [127:0] core_res = '0;

   // Core model: latch the job on aes_start, pulse aes_done core_lat cycles later.
   always @(negedge HCLK) begin
      aes_done = 1'b0;
      if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            aes_done = 1'b1;
            aes_dout = core_res;
         end
      end
      if (aes_start) begin
         core_res = core_fn(aes_key, aes_din);
         core_cnt = core_lat;
         starts++;
      end
   end

   // Reference model state.
   logic [127:0] in_q[$];
   logic [127:0] out_q[$];
   logic [127:0] m_key;
   bit           m_en, m_irq_en, m_ovf, m_udf;

   function automatic logic [31:0] m_status();
      logic [31:0] s = '0;
      s[1]     = (in_q.size() == IN_DEPTH);
      s[2]     = (in_q.size() == 0);
      s[3]     = (out_q.size() == OUT_DEPTH);
      s[4]     = (out_q.size() == 0);
      s[5]     = m_ovf;
      s[6]     = m_udf;
      s[11:8]  = 4'(in_q.size());
      s[15:12] = 4'(out_q.size());
      return s;
   endfunction

   // At quiescence every dispatchable block has been encrypted with the current key.
   function automatic void m_dispatch();
      while (m_en && in_q.size() > 0 && out_q.size() < OUT_DEPTH)
         out_q.push_back(core_fn(m_key, in_q.pop_front()));
   endfunction

   // One AHB single transfer. rsp: 0 OKAY, 1 proper two-cycle ERROR, 2 malformed response.
   task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] size, output logic [31:0] rd, output int rsp);
      HSELx = 1'b1; HADDR = addr; HWRITE = wr; HSIZE = size; HTRANS = 2'b10;
      @(posedge HCLK); #1;
      HSELx = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = '0; HWDATA = wd;
      rd  = HRDATA;
      rsp = 0;
      if (!HREADYOUT) begin
         rsp = HRESP ? 1 : 2;
         @(posedge HCLK); #1;
         if (!(HREADYOUT && HRESP)) rsp = 2;
      end else if (HRESP) begin
         rsp = 2;
      end
      @(posedge HCLK); #1;
   endtask

   task automatic wr32(input logic [31:0] off, input logic [31:0] d);
      logic [31:0] r;
      int          rsp;
      ahb_xfer(1'b1, BASE + off, d, 3'b010, r, rsp);
      check($sformatf("wr_resp@%0h", off), 128'(rsp), 128'd0);
   endtask

   task automatic rd32(input logic [31:0] off, output logic [31:0] d);
      int rsp;
      ahb_xfer(1'b0, BASE + off, 32'h0, 3'b010, d, rsp);
      check($sformatf("rd_resp@%0h", off), 128'(rsp), 128'd0);
   endtask

   task automatic err_xfer(input string tag, input logic wr, input logic [31:0] addr, input logic [2:0] size);
      logic [31:0] r;
      int          rsp;
      ahb_xfer(wr, addr, 32'hdead_beef, size, r, rsp);
      check(tag, 128'(rsp), 128'd1);
   endtask

   task automatic push_block(input logic [127:0] b);
      for (int i = 0; i < 4; i++) wr32(O_DIN + 32'(4 * i), b[32*i +: 32]);
   endtask

   task automatic read_block(output logic [127:0] b);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) begin
         rd32(O_DOUT + 32'(4 * i), w);
         b[32*i +: 32] = w;
      end
   endtask

   task automatic write_key(input logic [127:0] k);
      for (int i = 0; i < 4; i++) wr32(O_KEY + 32'(4 * i), k[32*i +: 32]);
   endtask

   task automatic settle(input int n);
      repeat (n) begin
         @(posedge HCLK);
      end
      #1;
   endtask

   task automatic do_reset();
      HSELx = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      #1 HRESETn = 1'b0;
      settle(2);
      HRESETn = 1'b1;
      settle(1);
   endtask

   task automatic expect_status(input string tag, input logic [31:0] exp);
      logic [31:0] s;
      rd32(O_STAT, s);
      check(tag, s, exp);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [127:0] blk, got, exp, k;
   logic [31:0]  w;
   int           op, s0, n;

   initial begin
      // Reset state
      settle(1);
      check("rst_hreadyout", HREADYOUT, 1'b1);
      check("rst_hresp", HRESP, 1'b0);
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_irq", irq, 1'b0);
      check("rst_start", aes_start, 1'b0);
      HRESETn = 1'b1;
      settle(1);
      expect_status("rst_status", 32'h0000_0014);
      rd32(O_CTRL, w);
      check("rst_ctrl", w, 32'h0);

      // Randomized operations against the reference model, checked at quiescence.
      in_q.delete(); out_q.delete();
      m_key = '0; m_en = 0; m_irq_en = 0; m_ovf = 0; m_udf = 0;
      for (int it = 0; it < 60; it++) begin
         core_lat = $urandom_range(1, 8);
         op = $urandom_range(0, 6);
         case (op)
            0, 1: begin
               blk = {$urandom, $urandom, $urandom, $urandom};
               push_block(blk);
               if (in_q.size() == IN_DEPTH) m_ovf = 1;
               else                         in_q.push_back(blk);
            end
            2, 3: begin
               read_block(got);
               if (out_q.size() == 0) begin
                  m_udf = 1;
                  check("dout_empty", got[127:96], 32'h0);
               end else begin
                  exp = out_q.pop_front();
                  check("dout", got, exp);
               end
            end
            4: begin
               k = {$urandom, $urandom, $urandom, $urandom};
               write_key(k);
               m_key = k;
            end
            5: begin
               w = {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
               wr32(O_CTRL, w);
               m_en = w[0];
               m_irq_en = w[1];
            end
            default: begin
               w = $urandom & 32'h60;
               wr32(O_CLR, w);
               if (w[5]) m_ovf = 0;
               if (w[6]) m_udf = 0;
            end
         endcase
         settle(80);
         m_dispatch();
         expect_status("status", m_status());
         check("irq", irq, m_irq_en && out_q.size() > 0);
      end

      // FIPS-197 vector, dispatch latency, key snapshot, key write while WAIT
      do_reset();
      core_lat = 10;
      write_key(FIPS_KEY);
      wr32(O_CTRL, 32'h1);
      push_block(FIPS_PT);
      check("fips_start_early", aes_start, 1'b0);
      settle(1);
      check("fips_start", aes_start, 1'b1);
      check("fips_key", aes_key, FIPS_KEY);
      check("fips_din", aes_din, FIPS_PT);
      wr32(O_KEY, 32'h0);
      settle(20);
      expect_status("fips_status", 32'h0000_1004);
      read_block(got);
      check("fips_ct", got, FIPS_CT);
      expect_status("fips_drained", 32'h0000_0014);

      // Overflow with EN=0, then clear OVF
      do_reset();
      for (int i = 0; i <= IN_DEPTH; i++) push_block({4{32'(i)}});
      expect_status("ovf_status", 32'h0000_0432);
      wr32(O_CLR, 32'h20);
      expect_status("ovf_cleared", 32'h0000_0412);

      // Output FIFO full stalls dispatch; one DOUT3 read releases the next job
      do_reset();
      core_lat = 20;
      wr32(O_CTRL, 32'h1);
      for (int i = 0; i < OUT_DEPTH; i++) push_block({4{32'h1000 + 32'(i)}});
      settle(130);
      push_block({4{32'h2000}});
      settle(10);
      expect_status("stall_status", 32'h0000_4108);
      read_block(got);
      check("stall_dout", got, core_fn('0, {4{32'h1000}}));
      check("stall_held", aes_start, 1'b0);
      settle(1);
      check("stall_release", aes_start, 1'b1);
      settle(30);

      // ERROR responses with no side effects
      do_reset();
      wr32(O_KEY, 32'h1111_1111);
      err_xfer("err_rd_2c", 1'b0, BASE + 32'h2C, 3'b010);
      err_xfer("err_byte_wr", 1'b1, BASE + O_KEY, 3'b000);
      err_xfer("err_rd_din", 1'b0, BASE + O_DIN, 3'b010);
      err_xfer("err_wr_status", 1'b1, BASE + O_STAT, 3'b010);
      err_xfer("err_rd_40", 1'b0, BASE + 32'h40, 3'b010);
      rd32(O_KEY, w);
      check("err_key_kept", w, 32'h1111_1111);
      expect_status("err_status", 32'h0000_0014);

      // FLUSH while WAIT: drain, discard the late result
      do_reset();
      core_lat = 20;
      s0 = starts;
      wr32(O_CTRL, 32'h1);
      push_block({4{32'habcd_0001}});
      settle(5);
      expect_status("flush_wait", 32'h0000_0111);
      wr32(O_CTRL, 32'h5);
      expect_status("flush_drain", 32'h0000_0015);
      settle(30);
      expect_status("flush_idle", 32'h0000_0014);
      check("flush_starts", 128'(starts - s0), 128'd1);
      rd32(O_CTRL, w);
      check("flush_ctrl", w, 32'h1);

      // irq follows the output FIFO one edge late
      do_reset();
      core_lat = 4;
      wr32(O_CTRL, 32'h3);
      push_block({4{32'h0bad_cafe}});
      n = 0;
      do begin
         @(negedge HCLK); #1;
         n++;
      end while (!aes_done && n < 50);
      check("irq_done_seen", aes_done, 1'b1);
      settle(1);
      check("irq_at_push", irq, 1'b0);
      settle(1);
      check("irq_rise", irq, 1'b1);
      read_block(got);
      check("irq_dout", got, core_fn('0, {4{32'h0bad_cafe}}));
      check("irq_at_pop", irq, 1'b1);
      settle(1);
      check("irq_fall", irq, 1'b0);

      // Reset mid-job; the late aes_done must be ignored
      do_reset();
      core_lat = 20;
      wr32(O_CTRL, 32'h1);
      push_block({4{32'h5555_aaaa}});
      settle(5);
      s0 = starts;
      do_reset();
      settle(30);
      expect_status("rst_mid_status", 32'h0000_0014);
      rd32(O_CTRL, w);
      check("rst_mid_ctrl", w, 32'h0);
      check("rst_mid_irq", irq, 1'b0);
      check("rst_mid_starts", 128'(starts - s0), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
